// File: rtl/spn_decrypt_core.sv
// spn_decrypt_core: iterative 3-round decryptor for the 16-bit SPN toy cipher.
// Performs one inverse round per clock, then holds the plaintext until it is taken.
module spn_decrypt_core #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned KEY_W  = 32,
  parameter int unsigned ROUNDS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEY_W-1:0]  in_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int unsigned RCNT_W = $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   s_q, s_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
  logic                in_ready_q, out_valid_q, busy_q;
  logic [DATA_W-1:0]   rk;
  logic [DATA_W-1:0]   mixed;
  logic [DATA_W-1:0]   step_s;

  // Inverse S-box on one nibble.
  function automatic logic [3:0] inv_sbox(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'h6;  4'h1: r = 4'h7;  4'h2: r = 4'hC;  4'h3: r = 4'h8;
      4'h4: r = 4'h9;  4'h5: r = 4'hE;  4'h6: r = 4'hB;  4'h7: r = 4'h1;
      4'h8: r = 4'hD;  4'h9: r = 4'h4;  4'hA: r = 4'hF;  4'hB: r = 4'h5;
      4'hC: r = 4'hA;  4'hD: r = 4'h2;  4'hE: r = 4'h0;  default: r = 4'h3;
    endcase
    return r;
  endfunction

  // Inverse S-box applied to all four nibbles.
  function automatic logic [15:0] inv_sub(input logic [15:0] x);
    logic [15:0] r;
    for (int n = 0; n < 4; n++) begin
      r[4*n +: 4] = inv_sbox(x[4*n +: 4]);
    end
    return r;
  endfunction

  // 4x4 bit transpose; it is its own inverse.
  function automatic logic [15:0] perm(input logic [15:0] x);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        r[4*j+i] = x[4*i+j];
      end
    end
    return r;
  endfunction

  // One inverse round: round 3 has no permutation, rounds 2 and 1 do.
  always_comb begin
    rk = key_q[23:8];
    case (rcnt_q)
      RCNT_W'(3): rk = {key_q[7:0], key_q[31:24]};
      RCNT_W'(2): rk = key_q[15:0];
      default:    rk = key_q[23:8];
    endcase
    mixed = s_q ^ rk;
    if (rcnt_q == RCNT_W'(ROUNDS)) begin
      step_s = inv_sub(mixed);
    end else begin
      step_s = inv_sub(perm(mixed));
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    key_d   = key_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = in_data;
          key_d   = in_key;
          rcnt_d  = RCNT_W'(ROUNDS);
          state_d = ROUND;
        end
      end
      ROUND: begin
        s_d    = step_s;
        rcnt_d = rcnt_q - RCNT_W'(1);
        if (rcnt_q == RCNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      key_q       <= '0;
      rcnt_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      key_q       <= key_d;
      rcnt_q      <= rcnt_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  // Final whitening with K0; only meaningful while out_valid is high.
  assign out_data  = s_q ^ key_q[31:16];

endmodule

// File: tb/tb_spn_decrypt_core.sv
// Directed and random self-checking bench for spn_decrypt_core.
module tb_spn_decrypt_core;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] in_data, out_data;
  logic [31:0] in_key;

  int errors = 0;
  int checks = 0;

  spn_decrypt_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] c;
    logic [31:0] k;
    logic [15:0] p;
  } vec_t;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'hE;  4'h1: r = 4'h7;  4'h2: r = 4'hD;  4'h3: r = 4'hF;
      4'h4: r = 4'h9;  4'h5: r = 4'hB;  4'h6: r = 4'h0;  4'h7: r = 4'h1;
      4'h8: r = 4'h3;  4'h9: r = 4'h4;  4'hA: r = 4'hC;  4'hB: r = 4'h6;
      4'hC: r = 4'h2;  4'hD: r = 4'h8;  4'hE: r = 4'h5;  default: r = 4'hA;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] sub16(input logic [15:0] x);
    return {sbox(x[15:12]), sbox(x[11:8]), sbox(x[7:4]), sbox(x[3:0])};
  endfunction

  // Output nibble j collects bit j of every input nibble.
  function automatic logic [15:0] tr16(input logic [15:0] x);
    logic [15:0] r;
    for (int j = 0; j < 4; j++) begin
      r[4*j +: 4] = {x[12+j], x[8+j], x[4+j], x[j]};
    end
    return r;
  endfunction

  function automatic logic [15:0] enc(input logic [15:0] p, input logic [31:0] k);
    logic [15:0] s;
    s = p ^ k[31:16];
    s = tr16(sub16(s)) ^ k[23:8];
    s = tr16(sub16(s)) ^ k[15:0];
    s = sub16(s) ^ {k[7:0], k[31:24]};
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one block from IDLE, check latency and result, then take the output.
  task automatic run_block(input logic [15:0] c, input logic [31:0] k, input logic [15:0] p);
    int lat;
    in_valid = 1'b1; in_data = c; in_key = k;
    chk("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 16'($urandom); in_key = $urandom;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    chk("out_data", 32'(out_data), 32'(p));
    chk("busy_done", 32'(busy), 32'd1);
    chk("in_ready_done", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
    chk("busy_after_hs", 32'(busy), 32'd0);
  endtask

  vec_t        tbl[6];
  logic [15:0] mid_s[3];
  logic [15:0] q[$];

  initial begin
    logic [15:0] p, held;
    logic [31:0] k;
    int cyc, last_acc, n_acc, n_out;
    logic acc, prev_ov, hs_prev;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;

    tbl[0] = '{c: 16'hA7AE, k: 32'h0000_0000, p: 16'h0000};
    tbl[1] = '{c: 16'h0000, k: 32'h0000_0000, p: 16'h643B};
    tbl[2] = '{c: enc(16'h1234, 32'hDEAD_BEEF), k: 32'hDEAD_BEEF, p: 16'h1234};
    tbl[3] = '{c: enc(16'hFFFF, 32'hFFFF_FFFF), k: 32'hFFFF_FFFF, p: 16'hFFFF};
    tbl[4] = '{c: enc(16'h0001, 32'h1234_5678), k: 32'h1234_5678, p: 16'h0001};
    tbl[5] = '{c: enc(16'hABCD, 32'hF0F0_A5A5), k: 32'hF0F0_A5A5, p: 16'hABCD};
    mid_s[0] = 16'h6666; mid_s[1] = 16'h6336; mid_s[2] = 16'h643B;

    // Reset values
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors; the first is accepted on the first edge after reset release
    for (int i = 0; i < 6; i++) begin
      run_block(tbl[i].c, tbl[i].k, tbl[i].p);
    end

    // Intermediate round states, then a 10-cycle stall in DONE
    in_valid = 1'b1; in_data = 16'h0000; in_key = 32'h0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_state", 32'(dut.s_q), 32'(mid_s[i]));
    end
    chk("stall_valid0", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid; in_data = 16'($urandom); in_key = $urandom;
      @(posedge clk); #1;
      chk("stall_data", 32'(out_data), 32'h643B);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall_release_ready", 32'(in_ready), 32'd1);
    chk("stall_release_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset in the second ROUND cycle
    in_valid = 1'b1; in_data = 16'h1234; in_key = 32'hCAFE_F00D;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("arst_no_pulse", 32'(out_valid), 32'd0);
    end
    run_block(16'hA7AE, 32'h0, 16'h0000);

    // 1000 random blocks with in_valid and out_ready held high
    p = 16'($urandom); k = $urandom;
    in_data = enc(p, k); in_key = k; in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0; last_acc = 0; n_acc = 0; n_out = 0; prev_ov = 1'b0; hs_prev = 1'b0;
    while (n_out < 1000 && cyc < 8000) begin
      acc = in_ready && in_valid;
      @(posedge clk); #1;
      cyc++;
      if (hs_prev) begin
        chk("rnd_busy_after_hs", 32'(busy), 32'd0);
        chk("rnd_ready_after_hs", 32'(in_ready), 32'd1);
      end
      hs_prev = out_valid;
      if (acc) begin
        if (n_acc > 0) chk("rnd_accept_interval", 32'(cyc - last_acc), 32'd5);
        last_acc = cyc;
        q.push_back(p);
        n_acc++;
        if (n_acc == 1000) begin
          in_valid = 1'b0;
        end else begin
          p = 16'($urandom); k = $urandom;
          in_data = enc(p, k); in_key = k;
        end
      end
      if (out_valid) begin
        chk("rnd_single_pulse", 32'(prev_ov), 32'd0);
        if (q.size() == 0) begin
          chk("rnd_unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          held = q.pop_front();
          chk("rnd_out_data", 32'(out_data), 32'(held));
        end
        n_out++;
      end
      prev_ov = out_valid;
    end
    chk("rnd_block_count", 32'(n_out), 32'd1000);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
